// File: rtl/address_offset_programmer_pkg.sv
// Shared types for the AOM configuration-port programmer: FSM states, the latched
// command record and the PO write-word packing helper.
package address_offset_programmer_pkg;

  localparam int unsigned AomAddrWidth      = 10;
  localparam int unsigned AomIncrWidth      = 4;
  localparam int unsigned AomEntryAddrWidth = 2;
  localparam int unsigned AomThreadWidth    = 3;
  localparam int unsigned AomEntryWidth     = AomIncrWidth + AomAddrWidth;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StWrite,
    StDone
  } state_e;

  typedef struct packed {
    logic                         is_po;
    logic [AomThreadWidth-1:0]    thread;
    logic [AomEntryAddrWidth-1:0] entry;
    logic [AomAddrWidth-1:0]      offset;
    logic [AomIncrWidth-1:0]      increment;
  } cmd_t;

  // The AOM stores a PO entry as {increment, offset}.
  function automatic logic [AomEntryWidth-1:0] pack_po_word(
    input logic [AomIncrWidth-1:0] increment,
    input logic [AomAddrWidth-1:0] offset
  );
    return {increment, offset};
  endfunction

endpackage

// File: rtl/aom_thread_mirror.sv
// Free-running modulo-THREAD_COUNT counter that tracks the AOM write-thread rotation.
// Exposes the current thread and the value it takes on the next clock.
module aom_thread_mirror #(
  parameter int unsigned THREAD_COUNT       = 8,
  parameter int unsigned THREAD_COUNT_WIDTH = 3,
  parameter int unsigned INITIAL_THREAD     = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  output logic [THREAD_COUNT_WIDTH-1:0] current_thread,
  output logic [THREAD_COUNT_WIDTH-1:0] next_thread
);

  logic [THREAD_COUNT_WIDTH-1:0] thread_q;

  always_comb begin
    if (thread_q == THREAD_COUNT_WIDTH'(THREAD_COUNT - 1)) begin
      next_thread = '0;
    end else begin
      next_thread = thread_q + THREAD_COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      thread_q <= THREAD_COUNT_WIDTH'(INITIAL_THREAD);
    end else begin
      thread_q <= next_thread;
    end
  end

  assign current_thread = thread_q;

endmodule

// File: rtl/address_offset_programmer.sv
// Command-driven writer for the AOM DO/PO configuration ports, slot-aligned to the
// AOM write-thread rotation. Optional AOM_PROGRAMMER_ERROR_EN adds cmd_error/error_seen.
module address_offset_programmer
  import address_offset_programmer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH          = 10,
  parameter int unsigned PO_INCR_WIDTH       = 4,
  parameter int unsigned PO_ENTRY_COUNT      = 4,
  parameter int unsigned PO_ENTRY_ADDR_WIDTH = 2,
  parameter int unsigned PO_ENTRY_WIDTH      = 14,
  parameter int unsigned PO_ADDR_WIDTH       = 5,
  parameter int unsigned THREAD_COUNT        = 8,
  parameter int unsigned THREAD_COUNT_WIDTH  = 3
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic                           cmd_is_po,
  input  logic [THREAD_COUNT_WIDTH-1:0]  cmd_thread,
  input  logic [PO_ENTRY_ADDR_WIDTH-1:0] cmd_po_entry,
  input  logic [ADDR_WIDTH-1:0]          cmd_offset,
  input  logic [PO_INCR_WIDTH-1:0]       cmd_increment,
  output logic                           po_wren,
  output logic [PO_ADDR_WIDTH-1:0]       po_write_addr,
  output logic [PO_ENTRY_WIDTH-1:0]      po_write_data,
  output logic                           do_wren,
  output logic [ADDR_WIDTH-1:0]          do_write_data,
  output logic                           cmd_done,
  output logic [THREAD_COUNT_WIDTH-1:0]  write_thread
`ifdef AOM_PROGRAMMER_ERROR_EN
  ,
  output logic                           cmd_error,
  output logic                           error_seen
`endif
);

  // The command record is sized by the package, so the widths must agree with it.
  if (THREAD_COUNT < 2 || THREAD_COUNT > (32'd1 << THREAD_COUNT_WIDTH) ||
      PO_ENTRY_COUNT != (32'd1 << PO_ENTRY_ADDR_WIDTH) ||
      PO_ENTRY_WIDTH != PO_INCR_WIDTH + ADDR_WIDTH ||
      PO_ADDR_WIDTH != THREAD_COUNT_WIDTH + PO_ENTRY_ADDR_WIDTH ||
      ADDR_WIDTH != AomAddrWidth || PO_INCR_WIDTH != AomIncrWidth ||
      PO_ENTRY_ADDR_WIDTH != AomEntryAddrWidth ||
      THREAD_COUNT_WIDTH != AomThreadWidth) begin : g_bad_params
    $error("address_offset_programmer: inconsistent parameters");
  end

  state_e                        state_q, state_d;
  cmd_t                          cmd_q, cmd_d, cmd_in, issue_cmd;
  logic [THREAD_COUNT_WIDTH-1:0] thread_now, thread_nxt;
  logic [ADDR_WIDTH-1:0]         do_data_q, do_data_d;
  logic [PO_ADDR_WIDTH-1:0]      po_addr_q, po_addr_d;
  logic [PO_ENTRY_WIDTH-1:0]     po_data_q, po_data_d;

  aom_thread_mirror #(
    .THREAD_COUNT       (THREAD_COUNT),
    .THREAD_COUNT_WIDTH (THREAD_COUNT_WIDTH),
    .INITIAL_THREAD     (1)
  ) u_thread_mirror (
    .clock          (clock),
    .reset          (reset),
    .current_thread (thread_now),
    .next_thread    (thread_nxt)
  );

  function automatic logic in_range(input logic [THREAD_COUNT_WIDTH-1:0] t);
    return 32'(t) < THREAD_COUNT;
  endfunction

  // Decided on next cycle's thread so the registered write lands in the qualifying slot.
  // PO avoids the target's own slot, where the AOM writes back the post-increment.
  function automatic logic can_issue(input cmd_t c, input logic [THREAD_COUNT_WIDTH-1:0] nxt);
    if (!in_range(c.thread)) begin
      return 1'b0;
    end
    return c.is_po ? (nxt != c.thread) : (nxt == c.thread);
  endfunction

  assign cmd_in = '{
    is_po:     cmd_is_po,
    thread:    cmd_thread,
    entry:     cmd_po_entry,
    offset:    cmd_offset,
    increment: cmd_increment
  };

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    issue_cmd = cmd_q;
    do_data_d = do_data_q;
    po_addr_d = po_addr_q;
    po_data_d = po_data_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          cmd_d     = cmd_in;
          issue_cmd = cmd_in;
          state_d   = can_issue(cmd_in, thread_nxt) ? StWrite : StWait;
        end
      end
      StWait: begin
        if (!in_range(cmd_q.thread)) begin
          state_d = StDone;
        end else if (can_issue(cmd_q, thread_nxt)) begin
          state_d = StWrite;
        end
      end
      StWrite: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (state_d == StWrite && state_q != StWrite) begin
      if (issue_cmd.is_po) begin
        po_addr_d = {issue_cmd.thread, issue_cmd.entry};
        po_data_d = pack_po_word(issue_cmd.increment, issue_cmd.offset);
      end else begin
        do_data_d = issue_cmd.offset;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      cmd_q     <= '0;
      do_data_q <= '0;
      po_addr_q <= '0;
      po_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      do_data_q <= do_data_d;
      po_addr_q <= po_addr_d;
      po_data_q <= po_data_d;
    end
  end

  assign cmd_ready     = (state_q == StIdle);
  assign cmd_done      = (state_q == StDone);
  assign do_wren       = (state_q == StWrite) && !cmd_q.is_po;
  assign po_wren       = (state_q == StWrite) && cmd_q.is_po;
  assign do_write_data = do_data_q;
  assign po_write_addr = po_addr_q;
  assign po_write_data = po_data_q;
  assign write_thread  = thread_now;

`ifdef AOM_PROGRAMMER_ERROR_EN
  logic error_seen_q;

  assign cmd_error = (state_q == StDone) && !in_range(cmd_q.thread);

  always_ff @(posedge clock) begin
    if (reset) begin
      error_seen_q <= 1'b0;
    end else if (cmd_error) begin
      error_seen_q <= 1'b1;
    end
  end

  assign error_seen = error_seen_q;
`endif

endmodule

// File: tb/tb_address_offset_programmer.sv
// Bench for address_offset_programmer: one DUT with 8 threads, one with 6 threads
// (to reach out-of-range thread ids), driven from a shared command bus.
module tb_address_offset_programmer;

  logic        clock;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_is_po;
  logic [2:0]  cmd_thread;
  logic [1:0]  cmd_po_entry;
  logic [9:0]  cmd_offset;
  logic [3:0]  cmd_increment;
  logic        sel;
  int          tc;
  int          cyc;
  int          n_checks;
  int          n_err;

  logic        a_valid, a_ready, a_po_wren, a_do_wren, a_done;
  logic [4:0]  a_po_addr;
  logic [13:0] a_po_data;
  logic [9:0]  a_do_data;
  logic [2:0]  a_wt;
  logic        b_valid, b_ready, b_po_wren, b_do_wren, b_done;
  logic [4:0]  b_po_addr;
  logic [13:0] b_po_data;
  logic [9:0]  b_do_data;
  logic [2:0]  b_wt;

  logic        o_ready, o_po_wren, o_do_wren, o_done;
  logic [4:0]  o_po_addr;
  logic [13:0] o_po_data;
  logic [9:0]  o_do_data;
  logic [2:0]  o_wt;

`ifdef AOM_PROGRAMMER_ERROR_EN
  logic a_cerr, a_eseen, b_cerr, b_eseen, o_cerr, o_eseen;
`endif

  assign a_valid = cmd_valid && !sel;
  assign b_valid = cmd_valid && sel;

  address_offset_programmer #(.THREAD_COUNT(8)) u_dut_a (
    .clock         (clock),
    .reset         (reset),
    .cmd_valid     (a_valid),
    .cmd_ready     (a_ready),
    .cmd_is_po     (cmd_is_po),
    .cmd_thread    (cmd_thread),
    .cmd_po_entry  (cmd_po_entry),
    .cmd_offset    (cmd_offset),
    .cmd_increment (cmd_increment),
    .po_wren       (a_po_wren),
    .po_write_addr (a_po_addr),
    .po_write_data (a_po_data),
    .do_wren       (a_do_wren),
    .do_write_data (a_do_data),
    .cmd_done      (a_done),
    .write_thread  (a_wt)
`ifdef AOM_PROGRAMMER_ERROR_EN
    ,
    .cmd_error     (a_cerr),
    .error_seen    (a_eseen)
`endif
  );

  address_offset_programmer #(.THREAD_COUNT(6)) u_dut_b (
    .clock         (clock),
    .reset         (reset),
    .cmd_valid     (b_valid),
    .cmd_ready     (b_ready),
    .cmd_is_po     (cmd_is_po),
    .cmd_thread    (cmd_thread),
    .cmd_po_entry  (cmd_po_entry),
    .cmd_offset    (cmd_offset),
    .cmd_increment (cmd_increment),
    .po_wren       (b_po_wren),
    .po_write_addr (b_po_addr),
    .po_write_data (b_po_data),
    .do_wren       (b_do_wren),
    .do_write_data (b_do_data),
    .cmd_done      (b_done),
    .write_thread  (b_wt)
`ifdef AOM_PROGRAMMER_ERROR_EN
    ,
    .cmd_error     (b_cerr),
    .error_seen    (b_eseen)
`endif
  );

  always_comb begin
    o_ready   = sel ? b_ready   : a_ready;
    o_po_wren = sel ? b_po_wren : a_po_wren;
    o_do_wren = sel ? b_do_wren : a_do_wren;
    o_done    = sel ? b_done    : a_done;
    o_po_addr = sel ? b_po_addr : a_po_addr;
    o_po_data = sel ? b_po_data : a_po_data;
    o_do_data = sel ? b_do_data : a_do_data;
    o_wt      = sel ? b_wt      : a_wt;
`ifdef AOM_PROGRAMMER_ERROR_EN
    o_cerr    = sel ? b_cerr    : a_cerr;
    o_eseen   = sel ? b_eseen   : a_eseen;
`endif
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Cycle index since reset release; cycle 0 is the first cycle with write_thread = 1.
  always @(posedge clock) begin
    if (reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  typedef struct {
    logic        sel;
    logic        is_po;
    logic [2:0]  thread;
    logic [1:0]  entry;
    logic [9:0]  offset;
    logic [3:0]  incr;
    int          exp_lat;
    int          exp_done;
    logic [13:0] exp_word;
    logic [4:0]  exp_addr;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: write_thread in cycle n is (1 + n) mod tc; the write lands in the first
  // cycle after accept whose thread qualifies (DO: equal, PO: different).
  function automatic void model(input logic is_po, input int thread, input int ntc,
                                input int acc, output int lat, output int done);
    lat  = -1;
    done = 2;
    if (thread >= ntc) return;
    for (int k = 1; k <= ntc + 1; k++) begin
      int w;
      w = (1 + acc + k) % ntc;
      if (is_po ? (w != thread) : (w == thread)) begin
        lat  = k;
        done = k + 1;
        return;
      end
    end
  endfunction

  task automatic do_reset();
    reset     = 1'b1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic run_cmd(input logic is_po, input logic [2:0] thread, input logic [1:0] entry,
                         input logic [9:0] offset, input logic [3:0] incr, input int exp_lat,
                         input int exp_done, input logic [13:0] exp_word,
                         input logic [4:0] exp_addr, input string tag);
    int   wlat, dlat, nwr, c;
    logic kind_po;
    logic [13:0] wword;
    logic [4:0]  waddr;
    bit   rdy_ok, wt_ok, fin;
`ifdef AOM_PROGRAMMER_ERROR_EN
    int   cerr_at_done, cerr_other;
    cerr_at_done = 0;
    cerr_other   = 0;
`endif
    for (int k = 0; k < 20 && !o_ready; k++) @(negedge clock);
    check({tag, "/ready_in"}, int'(o_ready), 1);
    cmd_valid     = 1'b1;
    cmd_is_po     = is_po;
    cmd_thread    = thread;
    cmd_po_entry  = entry;
    cmd_offset    = offset;
    cmd_increment = incr;
    @(negedge clock);
    cmd_valid = 1'b0;
    wlat = -1; dlat = -1; nwr = 0; rdy_ok = 1'b1; wt_ok = 1'b1; fin = 1'b0;
    kind_po = 1'b0; wword = '0; waddr = '0;
    c = 1;
    while (!fin) begin
      if (int'(o_wt) != (1 + cyc) % tc) wt_ok = 1'b0;
      if (o_do_wren && o_po_wren) nwr += 2;
      else if (o_do_wren || o_po_wren) begin
        nwr++;
        if (wlat < 0) begin
          wlat    = c;
          kind_po = o_po_wren;
          wword   = o_po_wren ? o_po_data : {4'b0, o_do_data};
          waddr   = o_po_addr;
        end
      end
`ifdef AOM_PROGRAMMER_ERROR_EN
      if (o_cerr && o_done) cerr_at_done++;
      else if (o_cerr) cerr_other++;
`endif
      if (dlat >= 0 && c == dlat + 1) begin
        if (!o_ready) rdy_ok = 1'b0;
        fin = 1'b1;
      end else begin
        if (o_ready) rdy_ok = 1'b0;
        if (o_done && dlat < 0) dlat = c;
        if (c >= 24) fin = 1'b1;
        else begin
          c++;
          @(negedge clock);
        end
      end
    end
    check({tag, "/lat"}, wlat, exp_lat);
    check({tag, "/done"}, dlat, exp_done);
    check({tag, "/nwrites"}, nwr, (exp_lat < 0) ? 0 : 1);
    check({tag, "/ready"}, int'(rdy_ok), 1);
    check({tag, "/wt"}, int'(wt_ok), 1);
    if (exp_lat >= 0) begin
      check({tag, "/kind"}, int'(kind_po), int'(is_po));
      check({tag, "/word"}, int'(wword), int'(exp_word));
      if (is_po) begin
        check({tag, "/addr"}, int'(waddr), int'(exp_addr));
        check({tag, "/hold"}, int'({o_po_addr, o_po_data}), int'({exp_addr, exp_word}));
      end else begin
        check({tag, "/hold"}, int'(o_do_data), int'(exp_word[9:0]));
      end
    end
`ifdef AOM_PROGRAMMER_ERROR_EN
    check({tag, "/cmd_error"}, cerr_at_done, (exp_lat < 0) ? 1 : 0);
    check({tag, "/cmd_error_stray"}, cerr_other, 0);
    if (exp_lat < 0) check({tag, "/error_seen"}, int'(o_eseen), 1);
`endif
  endtask

  initial begin
    int lat, done;
    logic [7:0] wr_mask, rdy_mask;
    int bad;
    n_checks = 0;
    n_err    = 0;
    sel = 1'b0; tc = 8;
    cmd_valid = 1'b0; cmd_is_po = 1'b0; cmd_thread = '0; cmd_po_entry = '0;
    cmd_offset = '0; cmd_increment = '0;

    //            sel   po    thr   ent   offset   inc   lat done word      addr
    vecs[0] = '{1'b0, 1'b0, 3'd3, 2'd0, 10'h055, 4'h0, 2, 3, 14'h0055, 5'h00};
    vecs[1] = '{1'b0, 1'b0, 3'd1, 2'd0, 10'h2aa, 4'h0, 8, 9, 14'h02aa, 5'h00};
    vecs[2] = '{1'b0, 1'b1, 3'd2, 2'd1, 10'h100, 4'h3, 2, 3, 14'h0d00, 5'b01001};
    vecs[3] = '{1'b0, 1'b1, 3'd5, 2'd2, 10'h3ff, 4'hf, 1, 2, 14'h3fff, 5'b10110};
    vecs[4] = '{1'b0, 1'b0, 3'd0, 2'd3, 10'h001, 4'h7, 7, 8, 14'h0001, 5'h00};
    vecs[5] = '{1'b1, 1'b0, 3'd7, 2'd0, 10'h0aa, 4'h0, -1, 2, 14'h0000, 5'h00};
    vecs[6] = '{1'b1, 1'b0, 3'd5, 2'd0, 10'h123, 4'h0, 4, 5, 14'h0123, 5'h00};
    vecs[7] = '{1'b1, 1'b1, 3'd2, 2'd3, 10'h200, 4'h9, 2, 3, 14'h2600, 5'b01011};
    vecs[8] = '{1'b1, 1'b1, 3'd6, 2'd1, 10'h111, 4'h1, -1, 2, 14'h0000, 5'h00};

    // Reset state of both instances.
    do_reset();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      check($sformatf("reset%0d/ready", s), int'(o_ready), 1);
      check($sformatf("reset%0d/wt", s), int'(o_wt), 1);
      check($sformatf("reset%0d/strobes", s), int'({o_do_wren, o_po_wren, o_done}), 0);
      check($sformatf("reset%0d/data", s), int'({o_po_addr, o_po_data, o_do_data}), 0);
    end

    foreach (vecs[i]) begin
      do_reset();
      sel = vecs[i].sel;
      tc  = vecs[i].sel ? 6 : 8;
      run_cmd(vecs[i].is_po, vecs[i].thread, vecs[i].entry, vecs[i].offset, vecs[i].incr,
              vecs[i].exp_lat, vecs[i].exp_done, vecs[i].exp_word, vecs[i].exp_addr,
              $sformatf("vec%0d", i));
    end

    // Reset while a DO command waits for its slot: no write, no completion.
    do_reset();
    sel = 1'b0; tc = 8;
    cmd_valid = 1'b1; cmd_is_po = 1'b0; cmd_thread = 3'd1; cmd_offset = 10'h0f0;
    @(negedge clock);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    bad = 0;
    repeat (3) begin
      @(negedge clock);
      if (o_do_wren || o_po_wren || o_done) bad++;
    end
    reset = 1'b0;
    check("midreset/ready", int'(o_ready), 1);
    check("midreset/wt", int'(o_wt), 1);
    repeat (10) begin
      if (o_do_wren || o_po_wren || o_done || !o_ready) bad++;
      @(negedge clock);
    end
    check("midreset/quiet", bad, 0);

    // Command held valid through DONE is only accepted in the following idle cycle.
    do_reset();
    sel = 1'b0; tc = 8;
    cmd_valid = 1'b1; cmd_is_po = 1'b1; cmd_thread = 3'd5; cmd_po_entry = 2'd0;
    cmd_offset = 10'h123; cmd_increment = 4'h1;
    for (int c = 0; c < 8; c++) begin
      if (c == 4) cmd_valid = 1'b0;
      wr_mask[c]  = o_po_wren;
      rdy_mask[c] = o_ready;
      @(negedge clock);
    end
    check("done_offer/po_wren", int'(wr_mask), 8'b0010_0010);
    check("done_offer/ready", int'(rdy_mask), 8'b1000_1001);

    // Randomized traffic against the reference model.
    do_reset();
    for (int n = 0; n < 80; n++) begin
      logic       r_po;
      logic [2:0] r_thr;
      logic [1:0] r_ent;
      logic [9:0] r_off;
      logic [3:0] r_inc;
      sel   = 1'($urandom_range(0, 1));
      tc    = sel ? 6 : 8;
      r_po  = 1'($urandom_range(0, 1));
      r_thr = 3'($urandom_range(0, 7));
      r_ent = 2'($urandom_range(0, 3));
      r_off = 10'($urandom_range(0, 1023));
      r_inc = 4'($urandom_range(0, 15));
      repeat ($urandom_range(0, 3)) @(negedge clock);
      model(r_po, int'(r_thr), tc, cyc, lat, done);
      run_cmd(r_po, r_thr, r_ent, r_off, r_inc, lat, done,
              r_po ? {r_inc, r_off} : {4'b0, r_off}, {r_thr, r_ent},
              $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
